// File: rtl/sram_arbiter.sv
// Two-port (Coco bus / SPI host) arbiter and fixed-timing sequencer for one 8-bit async SRAM.
// Define SRAM_ARB_RR_EN for round-robin tie-break; default is fixed Coco priority.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 4,
  parameter int ADDR_W        = 16
) (
  input  logic              clock_50,
  input  logic              reset,

  input  logic              coco_req,
  input  logic              coco_we,
  input  logic [ADDR_W-1:0] coco_addr,
  input  logic [7:0]        coco_wdata,
  output logic              coco_ack,
  output logic [7:0]        coco_rdata,

  input  logic              spi_req,
  input  logic              spi_we,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [7:0]        spi_wdata,
  output logic              spi_ack,
  output logic [7:0]        spi_rdata,

  output logic [ADDR_W-1:0] sram_addrbus,
  output logic [7:0]        sram_dout,
  output logic              sram_drive,
  input  logic [7:0]        sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,

  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(ACCESS_CYCLES - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        cnt_dec;
  logic              lat_we;

  logic              grant_any;
  logic              grant_spi;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

`ifdef SRAM_ARB_RR_EN
  // 1 when SPI received the most recent grant; starts at SPI so Coco wins the first tie
  logic last_spi;

  always_comb begin
    grant_any = coco_req | spi_req;
    if (coco_req && spi_req) begin
      grant_spi = ~last_spi;
    end else begin
      grant_spi = spi_req;
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      last_spi <= 1'b1;
    end else if (state == IDLE && grant_any) begin
      last_spi <= grant_spi;
    end
  end
`else
  always_comb begin
    grant_any = coco_req | spi_req;
    grant_spi = spi_req & ~coco_req;
  end
`endif

  always_comb begin
    sel_we    = grant_spi ? spi_we    : coco_we;
    sel_addr  = grant_spi ? spi_addr  : coco_addr;
    sel_wdata = grant_spi ? spi_wdata : coco_wdata;
    cnt_dec   = cnt - 3'd1;
  end

  assign busy = (state != IDLE);

  // Strobes are registered for the cycle being entered, so they are computed from the next cnt value.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      lat_we       <= 1'b0;
      owner        <= 1'b0;
      coco_ack     <= 1'b0;
      spi_ack      <= 1'b0;
      coco_rdata   <= 8'h00;
      spi_rdata    <= 8'h00;
      sram_addrbus <= '0;
      sram_dout    <= 8'h00;
      sram_drive   <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
    end else begin
      coco_ack <= 1'b0;
      spi_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state        <= ACCESS;
            cnt          <= CNT_LOAD;
            owner        <= grant_spi;
            lat_we       <= sel_we;
            sram_addrbus <= sel_addr;
            sram_dout    <= sel_wdata;
            sram_drive   <= sel_we;
            sram_ce_n    <= 1'b0;
            sram_oe_n    <= sel_we;
            sram_we_n    <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == 3'd0) begin
            state      <= RECOVER;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_drive <= 1'b0;
            if (owner) begin
              spi_ack <= 1'b1;
              if (!lat_we) spi_rdata <= sram_din;
            end else begin
              coco_ack <= 1'b1;
              if (!lat_we) coco_rdata <= sram_din;
            end
          end else begin
            cnt       <= cnt_dec;
            sram_we_n <= ~(lat_we && (cnt_dec != 3'd0) && (cnt_dec < CNT_LOAD));
          end
        end
        RECOVER: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: table of single accesses plus hand sequences for
// arbitration, reset abort and short request pulses.
module tb_sram_arbiter;

  localparam int AC = 4;
  localparam int AW = 16;

  logic          clock_50 = 1'b0;
  logic          reset    = 1'b0;
  logic          coco_req = 1'b0, coco_we = 1'b0;
  logic [AW-1:0] coco_addr = '0;
  logic [7:0]    coco_wdata = 8'h00;
  logic          coco_ack;
  logic [7:0]    coco_rdata;
  logic          spi_req = 1'b0, spi_we = 1'b0;
  logic [AW-1:0] spi_addr = '0;
  logic [7:0]    spi_wdata = 8'h00;
  logic          spi_ack;
  logic [7:0]    spi_rdata;
  logic [AW-1:0] sram_addrbus;
  logic [7:0]    sram_dout;
  logic          sram_drive;
  logic [7:0]    sram_din = 8'h00;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  logic          busy, owner;

  sram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(AW)) dut (
    .clock_50(clock_50), .reset(reset),
    .coco_req(coco_req), .coco_we(coco_we), .coco_addr(coco_addr), .coco_wdata(coco_wdata),
    .coco_ack(coco_ack), .coco_rdata(coco_rdata),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_ack(spi_ack), .spi_rdata(spi_rdata),
    .sram_addrbus(sram_addrbus), .sram_dout(sram_dout), .sram_drive(sram_drive),
    .sram_din(sram_din), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .busy(busy), .owner(owner)
  );

  always #10 clock_50 = ~clock_50;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_c_rd = 8'h00;
  logic [7:0] exp_s_rd = 8'h00;

  typedef struct {
    logic          is_spi;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    din;
    int            exp_we_low;
    int            exp_oe_low;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    coco_req = 1'b0;
    spi_req  = 1'b0;
    repeat (2) @(posedge clock_50);
    @(negedge clock_50);
    reset = 1'b1;
    @(posedge clock_50);
    #1;
  endtask

  // Starts at posedge+1; ends at posedge+1 with the DUT idle.
  task automatic run_vec(input vec_t v, input string tag);
    int ack_cyc, wrong_ack, ce_low, oe_low, we_low, drv;
    logic addr_ok, dout_ok, got_owner;
    logic [7:0] got_rd;
    ack_cyc = -1; wrong_ack = 0; ce_low = 0; oe_low = 0; we_low = 0; drv = 0;
    addr_ok = 1'b1; dout_ok = 1'b1; got_owner = 1'b0; got_rd = 8'h00;
    if (v.is_spi) begin
      spi_req = 1'b1; spi_we = v.we; spi_addr = v.addr; spi_wdata = v.wdata;
    end else begin
      coco_req = 1'b1; coco_we = v.we; coco_addr = v.addr; coco_wdata = v.wdata;
    end
    sram_din = ~v.din;
    for (int c = 0; c < 16 && ack_cyc < 0; c++) begin
      @(negedge clock_50);
      if (!sram_ce_n) begin
        ce_low++;
        if (sram_addrbus !== v.addr) addr_ok = 1'b0;
      end
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_low++;
      if (sram_drive) begin
        drv++;
        if (sram_dout !== v.wdata) dout_ok = 1'b0;
      end
      if ((v.is_spi ? coco_ack : spi_ack) === 1'b1) wrong_ack++;
      if ((v.is_spi ? spi_ack : coco_ack) === 1'b1) begin
        ack_cyc   = c;
        got_rd    = v.is_spi ? spi_rdata : coco_rdata;
        got_owner = owner;
      end
      // only the last ACCESS cycle sees the true byte, so an early or late capture shows up
      sram_din = (ce_low == AC) ? v.din : ~v.din;
      @(posedge clock_50);
      #1;
      if (c == 0) begin
        if (v.is_spi) begin
          spi_we = ~v.we; spi_addr = ~v.addr; spi_wdata = ~v.wdata;
        end else begin
          coco_we = ~v.we; coco_addr = ~v.addr; coco_wdata = ~v.wdata;
        end
      end
      if (ack_cyc >= 0) begin
        if (v.is_spi) spi_req = 1'b0; else coco_req = 1'b0;
      end
    end
    spi_req  = 1'b0;
    coco_req = 1'b0;
    if (!v.we) begin
      if (v.is_spi) exp_s_rd = v.din; else exp_c_rd = v.din;
    end
    check({tag, " ack_cycle"}, ack_cyc, AC + 1);
    check({tag, " other_ack"}, wrong_ack, 0);
    check({tag, " ce_low"}, ce_low, AC);
    check({tag, " oe_low"}, oe_low, v.exp_oe_low);
    check({tag, " we_low"}, we_low, v.exp_we_low);
    check({tag, " drive_cycles"}, drv, v.we ? AC : 0);
    check({tag, " addrbus"}, addr_ok, 1);
    check({tag, " dout"}, dout_ok, 1);
    check({tag, " owner"}, got_owner, v.is_spi);
    check({tag, " rdata_at_ack"}, got_rd, v.is_spi ? exp_s_rd : exp_c_rd);
    @(negedge clock_50);
    check({tag, " busy_after"}, busy, 0);
    check({tag, " ack_one_cycle"}, {coco_ack, spi_ack}, 0);
    check({tag, " coco_rdata_held"}, coco_rdata, exp_c_rd);
    check({tag, " spi_rdata_held"}, spi_rdata, exp_s_rd);
    @(posedge clock_50);
    #1;
  endtask

  vec_t vecs [6];

  initial begin
    int c_ack, s_ack, acks, ce_low, cacks, sacks;
    logic [3:0] seq_port;
    int seq_cyc [4];
    logic [3:0] exp_seq;

    vecs[0] = '{1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00, 2, 0};
    vecs[1] = '{1'b0, 1'b0, 16'h7FE0, 8'h00, 8'h3C, 0, 4};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00, 2, 0};
    vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h81, 0, 4};
    vecs[4] = '{1'b0, 1'b0, 16'h8001, 8'h11, 8'h00, 0, 4};
    vecs[5] = '{1'b1, 1'b1, 16'h5A5A, 8'h00, 8'hEE, 2, 0};

    #35;
    check("reset ce/oe/we_n", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("reset drive/busy/owner", {sram_drive, busy, owner}, 3'b000);
    check("reset acks", {coco_ack, spi_ack}, 2'b00);
    check("reset addrbus/dout", {sram_addrbus, sram_dout}, 24'h0);
    check("reset rdata", {coco_rdata, spi_rdata}, 16'h0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous requests after reset: Coco first, SPI one full slot later.
    do_reset();
    c_ack = -1; s_ack = -1;
    coco_req = 1'b1; coco_we = 1'b0; coco_addr = 16'h0100;
    spi_req  = 1'b1; spi_we  = 1'b1; spi_addr  = 16'h0200; spi_wdata = 8'h5C;
    sram_din = 8'h77;
    for (int c = 0; c < 20 && s_ack < 0; c++) begin
      @(negedge clock_50);
      if (coco_ack) c_ack = c;
      if (spi_ack) s_ack = c;
      @(posedge clock_50);
      #1;
      if (c_ack >= 0) coco_req = 1'b0;
      if (s_ack >= 0) spi_req = 1'b0;
    end
    coco_req = 1'b0; spi_req = 1'b0;
    check("tie coco_ack_cycle", c_ack, AC + 1);
    check("tie spi_ack_cycle", s_ack, 2 * AC + 3);
    check("tie coco_rdata", coco_rdata, 8'h77);

    // Both requests held: grant order depends on the arbitration build.
    do_reset();
    acks = 0; seq_port = 4'h0;
    for (int k = 0; k < 4; k++) seq_cyc[k] = -1;
    coco_req = 1'b1; coco_we = 1'b1; coco_addr = 16'h0010; coco_wdata = 8'h01;
    spi_req  = 1'b1; spi_we  = 1'b1; spi_addr  = 16'h0020; spi_wdata = 8'h02;
    for (int c = 0; c < 30 && acks < 4; c++) begin
      @(negedge clock_50);
      if (coco_ack || spi_ack) begin
        seq_port[acks] = spi_ack;
        seq_cyc[acks]  = c;
        acks++;
      end
      @(posedge clock_50);
      #1;
    end
    coco_req = 1'b0; spi_req = 1'b0;
`ifdef SRAM_ARB_RR_EN
    exp_seq = 4'b1010;
`else
    exp_seq = 4'b0000;
`endif
    for (int k = 0; k < 4; k++) begin
      check($sformatf("held grant%0d port", k), seq_port[k], exp_seq[k]);
      check($sformatf("held grant%0d ack_cycle", k), seq_cyc[k], k * (AC + 2) + AC + 1);
    end
    repeat (3) @(posedge clock_50);
    #1;

    // Reset asserted mid-write: strobes release at once and no ack follows.
    spi_req = 1'b1; spi_we = 1'b1; spi_addr = 16'h1111; spi_wdata = 8'h22;
    repeat (2) @(posedge clock_50);
    #3;
    check("abort we_n low before reset", sram_we_n, 0);
    reset = 1'b0;
    #1;
    check("abort strobes high", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    check("abort drive/busy", {sram_drive, busy}, 2'b00);
    spi_req = 1'b0;
    @(negedge clock_50);
    reset = 1'b1;
    acks = 0; ce_low = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock_50);
      if (coco_ack || spi_ack) acks++;
      if (!sram_ce_n) ce_low++;
    end
    check("abort no ack", acks, 0);
    check("abort no access", ce_low, 0);
    @(posedge clock_50);
    #1;
    run_vec('{1'b1, 1'b0, 16'h2468, 8'h00, 8'h9D, 0, 4}, "post_abort");

    // Coco pulses its request for one cycle while SPI owns the SRAM.
    cacks = 0; sacks = 0; ce_low = 0;
    spi_req = 1'b1; spi_we = 1'b0; spi_addr = 16'h4000;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin
        coco_req = 1'b1; coco_we = 1'b1; coco_addr = 16'h4444; coco_wdata = 8'h44;
      end
      if (c == 3) coco_req = 1'b0;
      @(negedge clock_50);
      if (coco_ack) cacks++;
      if (spi_ack) sacks++;
      if (!sram_ce_n) ce_low++;
      @(posedge clock_50);
      #1;
      if (sacks > 0) spi_req = 1'b0;
    end
    check("pulse coco_ack count", cacks, 0);
    check("pulse spi_ack count", sacks, 1);
    check("pulse access cycles", ce_low, AC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
